// File: rtl/ws2812_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812_pkg                                                      |
// | Purpose  : Shared WS2812 decoder states and 12 MHz nominal line timing.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        READY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    localparam int c_T0H    = 5;
    localparam int c_T1H    = 10;
    localparam int c_TBIT   = 15;
    localparam int c_TRESET = 600;

endpackage
`default_nettype wire

// File: rtl/ws2812_decoder_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_edge                                                       |
// | Purpose  : Two-flop synchronizer with registered previous sample for edges.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic ds,
    output logic rise,
    output logic fall
);

    logic r_meta_q, w_meta_d;
    logic r_ds_q,   w_ds_d;
    logic r_prev_q, w_prev_d;

    always_comb begin
        w_meta_d = din;
        w_ds_d   = r_meta_q;
        w_prev_d = r_ds_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= 1'b0;
            r_ds_q   <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_meta_q <= w_meta_d;
            r_ds_q   <= w_ds_d;
            r_prev_q <= w_prev_d;
        end
    end

    assign ds   = r_ds_q;
    assign rise = r_ds_q & ~r_prev_q;
    assign fall = ~r_ds_q & r_prev_q;

endmodule
`default_nettype wire

// File: rtl/ws2812_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812_decoder                                                  |
// | Purpose  : Decodes a WS2812 NRZ line into 24-bit GRB pixels and frames.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH   = (c_T0H + c_T1H) / 2,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = c_TBIT - 1,
    parameter int RESET_CYCLES = c_TRESET,
    parameter int MAX_PIXELS   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din,
    output logic [23:0]                   pixel_data,
    output logic                          pixel_valid,
    output logic [$clog2(MAX_PIXELS)-1:0] pixel_index,
    output logic                          frame_done,
    output logic [$clog2(MAX_PIXELS):0]   frame_pixels,
    output logic                          error
);

    localparam int c_IDX_W = $clog2(MAX_PIXELS);
    localparam int c_CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [c_CNT_W-1:0] c_RESET   = c_CNT_W'(RESET_CYCLES);
    localparam logic [c_CNT_W-1:0] c_THRESH  = c_CNT_W'(BIT_THRESH);
    localparam logic [c_CNT_W-1:0] c_MIN_HI  = c_CNT_W'(MIN_HIGH);
    localparam logic [c_CNT_W-1:0] c_MAX_HI  = c_CNT_W'(MAX_HIGH);
    localparam logic [c_IDX_W:0]   c_PIX_MAX = (c_IDX_W + 1)'(MAX_PIXELS);

    logic w_ds, w_rise, w_fall;

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .ds   (w_ds),
        .rise (w_rise),
        .fall (w_fall)
    );

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [4:0]           r_bits_q,  w_bits_d;
    logic [22:0]          r_shift_q, w_shift_d;
    logic [c_IDX_W:0]     r_pix_q,   w_pix_d;

    logic [23:0]          r_pixel_data_q,   w_pixel_data_d;
    logic                 r_pixel_valid_q,  w_pixel_valid_d;
    logic [c_IDX_W-1:0]   r_pixel_index_q,  w_pixel_index_d;
    logic                 r_frame_done_q,   w_frame_done_d;
    logic [c_IDX_W:0]     r_frame_pixels_q, w_frame_pixels_d;
    logic                 r_error_q,        w_error_d;

    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_bit;
    logic [23:0]          w_word;

    always_comb begin
        w_cnt_inc = (r_cnt_q == c_CNT_MAX) ? r_cnt_q : r_cnt_q + c_CNT_ONE;
        w_bit     = (r_cnt_q >= c_THRESH);
        w_word    = {r_shift_q, w_bit};

        w_state_d        = r_state_q;
        w_cnt_d          = r_cnt_q;
        w_bits_d         = r_bits_q;
        w_shift_d        = r_shift_q;
        w_pix_d          = r_pix_q;
        w_pixel_data_d   = r_pixel_data_q;
        w_pixel_valid_d  = 1'b0;
        w_pixel_index_d  = r_pixel_index_q;
        w_frame_done_d   = 1'b0;
        w_frame_pixels_d = r_frame_pixels_q;
        w_error_d        = 1'b0;

        case (r_state_q)
            SYNC: begin
                if (w_ds) begin
                    w_cnt_d = '0;
                end else if (w_cnt_inc >= c_RESET) begin
                    w_state_d = READY;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            READY: begin
                if (w_rise) begin
                    w_state_d = HIGH;
                    w_cnt_d   = c_CNT_ONE;
                end
            end

            HIGH: begin
                if (w_fall) begin
                    if (r_cnt_q < c_MIN_HI) begin
                        // Line is already low here, so this cycle starts the resync gap.
                        w_error_d = 1'b1;
                        w_state_d = SYNC;
                        w_cnt_d   = c_CNT_ONE;
                        w_bits_d  = '0;
                        w_pix_d   = '0;
                    end else begin
                        w_state_d = LOW;
                        w_cnt_d   = c_CNT_ONE;
                        if (r_bits_q == 5'd23) begin
                            w_bits_d = '0;
                            if (r_pix_q < c_PIX_MAX) begin
                                w_pixel_data_d  = w_word;
                                w_pixel_valid_d = 1'b1;
                                w_pixel_index_d = r_pix_q[c_IDX_W-1:0];
                                w_pix_d         = r_pix_q + 1'b1;
                            end else begin
                                w_error_d = 1'b1;
                            end
                        end else begin
                            w_bits_d  = r_bits_q + 5'd1;
                            w_shift_d = w_word[22:0];
                        end
                    end
                end else begin
                    w_cnt_d = w_cnt_inc;
                    if (w_cnt_inc > c_MAX_HI) begin
                        w_error_d = 1'b1;
                        w_state_d = SYNC;
                        w_cnt_d   = '0;
                        w_bits_d  = '0;
                        w_pix_d   = '0;
                    end
                end
            end

            LOW: begin
                if (r_cnt_q >= c_RESET) begin
                    // A partial word is discarded but complete pixels still close the frame.
                    w_error_d = (r_bits_q != 5'd0);
                    if (r_pix_q != '0) begin
                        w_frame_done_d   = 1'b1;
                        w_frame_pixels_d = r_pix_q;
                    end
                    w_bits_d  = '0;
                    w_pix_d   = '0;
                    w_state_d = w_rise ? HIGH : READY;
                    w_cnt_d   = w_rise ? c_CNT_ONE : '0;
                end else if (w_rise) begin
                    w_state_d = HIGH;
                    w_cnt_d   = c_CNT_ONE;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end

            default: begin
                w_state_d = SYNC;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q        <= SYNC;
            r_cnt_q          <= '0;
            r_bits_q         <= '0;
            r_shift_q        <= '0;
            r_pix_q          <= '0;
            r_pixel_data_q   <= '0;
            r_pixel_valid_q  <= 1'b0;
            r_pixel_index_q  <= '0;
            r_frame_done_q   <= 1'b0;
            r_frame_pixels_q <= '0;
            r_error_q        <= 1'b0;
        end else begin
            r_state_q        <= w_state_d;
            r_cnt_q          <= w_cnt_d;
            r_bits_q         <= w_bits_d;
            r_shift_q        <= w_shift_d;
            r_pix_q          <= w_pix_d;
            r_pixel_data_q   <= w_pixel_data_d;
            r_pixel_valid_q  <= w_pixel_valid_d;
            r_pixel_index_q  <= w_pixel_index_d;
            r_frame_done_q   <= w_frame_done_d;
            r_frame_pixels_q <= w_frame_pixels_d;
            r_error_q        <= w_error_d;
        end
    end

    assign pixel_data   = r_pixel_data_q;
    assign pixel_valid  = r_pixel_valid_q;
    assign pixel_index  = r_pixel_index_q;
    assign frame_done   = r_frame_done_q;
    assign frame_pixels = r_frame_pixels_q;
    assign error        = r_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ws2812_decoder                                               |
// | Purpose  : Self-checking bench for ws2812_decoder against a pulse model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ws2812_decoder;

    localparam int TH    = 7;
    localparam int MINH  = 2;
    localparam int MAXH  = 14;
    localparam int RST_C = 600;
    localparam int MAXP  = 64;
    localparam int IW    = $clog2(MAXP);

    typedef struct {
        logic [23:0] data;
        int          idx;
        int          cyc;
    } pix_ev_t;

    typedef struct {
        int hi;
        bit exp_err;
        bit exp_bit;
    } wvec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic [IW-1:0] pixel_index;
    logic          frame_done;
    logic [IW:0]   frame_pixels;
    logic          error;

    ws2812_decoder #(
        .BIT_THRESH   (TH),
        .MIN_HIGH     (MINH),
        .MAX_HIGH     (MAXH),
        .RESET_CYCLES (RST_C),
        .MAX_PIXELS   (MAXP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pix_ev_t obs_pix[$];
    pix_ev_t exp_pix[$];
    int      obs_fd[$];
    int      obs_fd_cyc[$];
    int      exp_fd[$];
    int      obs_err = 0;
    int      exp_err = 0;
    int      overlap = 0;
    bit      seg_lv[$];
    int      seg_len[$];
    int      last_fall = 0;
    int      n_tests = 0;
    int      n_fail = 0;
    pix_ev_t mon_ev;

    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid) begin
                mon_ev.data = pixel_data;
                mon_ev.idx  = int'(pixel_index);
                mon_ev.cyc  = cyc;
                obs_pix.push_back(mon_ev);
            end
            if (frame_done) begin
                obs_fd.push_back(int'(frame_pixels));
                obs_fd_cyc.push_back(cyc);
            end
            if (error) obs_err++;
            if (pixel_valid && frame_done) overlap++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Line segments are merged so each entry is one maximal run of a level.
    task automatic seg(input bit lvl, input int n);
        if (seg_lv.size() > 0 && seg_lv[seg_lv.size()-1] == lvl) begin
            seg_len[seg_len.size()-1] += n;
        end else begin
            seg_lv.push_back(lvl);
            seg_len.push_back(n);
            if (lvl == 1'b0) last_fall = cyc;
        end
        din = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int n);
        seg(1'b0, n);
    endtask

    task automatic send_bit(input bit b);
        seg(1'b1, b ? 10 : 5);
        seg(1'b0, b ? 5 : 10);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic begin_phase();
        din = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        obs_pix.delete();
        obs_fd.delete();
        obs_fd_cyc.delete();
        obs_err = 0;
        overlap = 0;
        seg_lv.delete();
        seg_len.delete();
    endtask

    // Reference model works on whole pulses: widths of high and low runs.
    task automatic model_run();
        int          st;
        int          bits;
        int          pix;
        int          len;
        logic [23:0] w;
        pix_ev_t     ev;
        exp_pix.delete();
        exp_fd.delete();
        exp_err = 0;
        st = 0; bits = 0; pix = 0; w = '0;
        for (int i = 0; i < seg_lv.size(); i++) begin
            len = seg_len[i];
            if (seg_lv[i] == 1'b0) begin
                if (len >= RST_C) begin
                    if (st == 2) begin
                        if (bits != 0) exp_err++;
                        if (pix > 0) exp_fd.push_back(pix);
                    end
                    st = 1; bits = 0; pix = 0;
                end
            end else if (st != 0) begin
                if (len > MAXH || len < MINH) begin
                    exp_err++;
                    st = 0; bits = 0; pix = 0;
                end else begin
                    w = {w[22:0], (len >= TH)};
                    bits++;
                    st = 2;
                    if (bits == 24) begin
                        bits = 0;
                        if (pix < MAXP) begin
                            ev.data = w;
                            ev.idx  = pix;
                            ev.cyc  = 0;
                            exp_pix.push_back(ev);
                            pix++;
                        end else begin
                            exp_err++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic end_phase(input string ph);
        model_run();
        check({ph, " pixel count"}, obs_pix.size(), exp_pix.size());
        for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++) begin
            check($sformatf("%s pix%0d data", ph, i), obs_pix[i].data, exp_pix[i].data);
            check($sformatf("%s pix%0d index", ph, i), obs_pix[i].idx, exp_pix[i].idx);
        end
        check({ph, " frame count"}, obs_fd.size(), exp_fd.size());
        for (int i = 0; i < obs_fd.size() && i < exp_fd.size(); i++)
            check($sformatf("%s frame%0d pixels", ph, i), obs_fd[i], exp_fd[i]);
        check({ph, " error pulses"}, obs_err, exp_err);
        check({ph, " valid/done overlap"}, overlap, 0);
    endtask

    initial begin
        wvec_t       wtab[6];
        logic [23:0] w3[3];
        logic [23:0] w;
        int          t_fall;
        int          nfr;
        int          npx;
        int          npart;
        int          kind;

        wtab[0] = '{6,  1'b0, 1'b0};
        wtab[1] = '{7,  1'b0, 1'b1};
        wtab[2] = '{14, 1'b0, 1'b1};
        wtab[3] = '{15, 1'b1, 1'b0};
        wtab[4] = '{1,  1'b1, 1'b0};
        wtab[5] = '{2,  1'b0, 1'b0};
        w3[0] = 24'h123456;
        w3[1] = 24'hABCDEF;
        w3[2] = 24'h000001;

        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pixel_data", pixel_data, 0);
        check("reset pixel_valid", pixel_valid, 0);
        check("reset pixel_index", pixel_index, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_pixels", frame_pixels, 0);
        check("reset error", error, 0);

        // Single nominal pixel with latency checks.
        begin_phase();
        gap(700);
        send_word(24'hFF0000);
        t_fall = last_fall;
        gap(700);
        end_phase("single");
        check("single strobes", obs_pix.size(), 1);
        if (obs_pix.size() > 0) begin
            check("single data", obs_pix[0].data, 24'hFF0000);
            check("single index", obs_pix[0].idx, 0);
            check("single valid latency", obs_pix[0].cyc - t_fall, 3);
        end
        check("single frames", obs_fd.size(), 1);
        if (obs_fd.size() > 0 && obs_pix.size() > 0) begin
            check("single frame_pixels", obs_fd[0], 1);
            check("single done spacing", obs_fd_cyc[0] - obs_pix[0].cyc, RST_C);
        end
        check("single error", obs_err, 0);

        // Three-pixel frame.
        begin_phase();
        gap(700);
        for (int i = 0; i < 3; i++) send_word(w3[i]);
        gap(700);
        end_phase("three");
        check("three strobes", obs_pix.size(), 3);
        for (int i = 0; i < obs_pix.size() && i < 3; i++) begin
            check($sformatf("three const data%0d", i), obs_pix[i].data, w3[i]);
            check($sformatf("three const index%0d", i), obs_pix[i].idx, i);
        end
        if (obs_fd.size() > 0) check("three frame_pixels", obs_fd[0], 3);

        // Stream starting mid-traffic must be ignored until a full reset gap.
        begin_phase();
        send_word(24'hA5A5A5);
        send_word(24'h5A5A5A);
        gap(700);
        send_word(24'h00FF00);
        gap(700);
        end_phase("midstream");
        check("midstream strobes", obs_pix.size(), 1);
        if (obs_pix.size() > 0) check("midstream data", obs_pix[0].data, 24'h00FF00);

        // Width corners on the final bit of a word.
        for (int k = 0; k < 6; k++) begin
            begin_phase();
            gap(650);
            repeat (23) send_bit(1'b0);
            seg(1'b1, wtab[k].hi);
            seg(1'b0, 10);
            gap(650);
            end_phase($sformatf("width%0d", wtab[k].hi));
            if (wtab[k].exp_err) begin
                check($sformatf("width%0d strobes", wtab[k].hi), obs_pix.size(), 0);
                check($sformatf("width%0d error", wtab[k].hi), obs_err, 1);
            end else begin
                check($sformatf("width%0d strobes", wtab[k].hi), obs_pix.size(), 1);
                if (obs_pix.size() > 0)
                    check($sformatf("width%0d bit", wtab[k].hi), obs_pix[0].data, {23'd0, wtab[k].exp_bit});
                check($sformatf("width%0d error", wtab[k].hi), obs_err, 0);
            end
        end

        // Partial word followed by a reset gap.
        begin_phase();
        gap(650);
        repeat (12) send_bit(1'b1);
        gap(650);
        end_phase("partial");
        check("partial frames", obs_fd.size(), 0);
        check("partial error", obs_err, 1);

        // Overflow past MAX_PIXELS, then reset mid-pixel.
        begin_phase();
        gap(650);
        for (int i = 0; i < 65; i++) send_word(24'(i * 32'h030507 + 32'h100));
        gap(650);
        end_phase("overflow");
        check("overflow strobes", obs_pix.size(), 64);
        if (obs_pix.size() > 0) check("overflow last index", obs_pix[obs_pix.size()-1].idx, 63);
        if (obs_fd.size() > 0) check("overflow frame_pixels", obs_fd[0], 64);
        check("overflow error", obs_err, 1);
        repeat (10) send_bit(1'b1);
        seg(1'b1, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst pixel_data", pixel_data, 0);
        check("midrst pixel_valid", pixel_valid, 0);
        check("midrst pixel_index", pixel_index, 0);
        check("midrst frame_done", frame_done, 0);
        check("midrst frame_pixels", frame_pixels, 0);
        check("midrst error", error, 0);

        // Randomized frames with jittered widths and rare injected faults.
        for (int r = 0; r < 3; r++) begin
            begin_phase();
            gap(650);
            nfr = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++) begin
                npx = int'($urandom_range(0, 2));
                for (int p = 0; p < npx; p++) begin
                    w = 24'($urandom);
                    for (int b = 23; b >= 0; b--) begin
                        kind = int'($urandom_range(0, 199));
                        if (kind == 0)
                            seg(1'b1, 1);
                        else if (kind == 1)
                            seg(1'b1, int'($urandom_range(15, 20)));
                        else if (w[b])
                            seg(1'b1, int'($urandom_range(7, 14)));
                        else
                            seg(1'b1, int'($urandom_range(2, 6)));
                        seg(1'b0, int'($urandom_range(3, 12)));
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    npart = int'($urandom_range(1, 23));
                    for (int b = 0; b < npart; b++) send_bit(1'($urandom));
                end
                gap(int'($urandom_range(620, 700)));
            end
            end_phase($sformatf("random%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
